// File: rtl/abft_ctrl_pkg.sv
// Shared types and timing helpers for the ABFT checked-tile controller.
package abft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    CHECK,
    DONE
  } ctrlState_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_FAIL  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  // Column checksums appear at the array edge after 2N-1 cycles, full result at 3N-1.
  function automatic int dot_cycle_of(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int acc_cycle_of(input int n);
    return 3 * n - 1;
  endfunction

endpackage

// File: rtl/abft_check_ctrl_run_timer.sv
// Loadable up-counter with synchronous clear and a terminal-value compare.
module run_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic [W-1:0] term_value,
  output logic [W-1:0] count,
  output logic         at_terminal
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == term_value);

endmodule

// File: rtl/abft_check_ctrl.sv
// Sequences one checked tile on the systolic array and ABFT detector, with retry on error.
// Optional build macro ABFT_ERR_CNT_EN adds the saturating err_events counter output.
module abft_check_ctrl
  import abft_ctrl_pkg::*;
#(
  parameter int arraySize  = 4,
  parameter int maxRetries = 2,
  parameter int runCycles  = 3 * arraySize,
  parameter int dotCycle   = dot_cycle_of(arraySize),
  parameter int accCycle   = acc_cycle_of(arraySize),
  parameter int checkWait  = 2,
  parameter int cntWidth   = $clog2(3 * arraySize + 1),
  parameter int retryWidth = (maxRetries > 0) ? $clog2(maxRetries + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  abort,
  output logic                  array_clr,
  output logic                  array_en,
  output logic                  det_clr,
  output logic                  dot_valid,
  output logic                  acc_valid,
  input  logic [3:0]            det_error,
  output logic                  done,
  output logic [1:0]            status,
  output logic [3:0]            err_flags,
  output logic [retryWidth-1:0] retry_count,
  output logic                  busy
`ifdef ABFT_ERR_CNT_EN
  ,
  output logic [15:0]           err_events
`endif
);

  ctrlState_t state, state_next;

  logic [cntWidth-1:0]   cnt;
  logic [cntWidth-1:0]   cnt_term;
  logic                  cnt_at_term;
  logic                  cnt_clr;
  logic                  cnt_load;
  logic                  cnt_en;
  logic [retryWidth-1:0] retries;
  logic                  accept;
  logic                  sample;
  logic                  has_error;
  logic                  can_retry;
  logic                  in_flight;

  assign accept    = start_valid && (state == IDLE);
  assign in_flight = (state == PREP) || (state == RUN) || (state == CHECK);
  assign sample    = (state == CHECK) && cnt_at_term;
  assign has_error = |det_error;
  assign can_retry = retries < retryWidth'(maxRetries);

  // One timer serves both phases: it counts run cycles, then is reloaded to zero for the check wait.
  assign cnt_term = (state == RUN) ? cntWidth'(runCycles - 1) : cntWidth'(checkWait - 1);
  assign cnt_clr  = !((state == RUN) || (state == CHECK));
  assign cnt_load = (state == RUN) && cnt_at_term;
  assign cnt_en   = (state == RUN) || (state == CHECK);

  run_timer #(
    .W(cntWidth)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .load       (cnt_load),
    .load_value ('0),
    .en         (cnt_en),
    .term_value (cnt_term),
    .count      (cnt),
    .at_terminal(cnt_at_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort wins over every other transition, including a same-cycle check result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid) state_next = PREP;
      PREP:    state_next = abort ? DONE : RUN;
      RUN: begin
        if (abort) begin
          state_next = DONE;
        end else if (cnt_at_term) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_next = DONE;
        end else if (sample) begin
          state_next = (has_error && can_retry) ? PREP : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    array_clr   = 1'b0;
    array_en    = 1'b0;
    dot_valid   = 1'b0;
    acc_valid   = 1'b0;
    done        = 1'b0;
    det_clr     = rst;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      PREP: begin
        array_clr = 1'b1;
        det_clr   = 1'b1;
      end
      RUN: begin
        array_en  = 1'b1;
        dot_valid = (cnt == cntWidth'(dotCycle)) || (cnt == cntWidth'(dotCycle + 1));
        acc_valid = (cnt == cntWidth'(accCycle));
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result registers hold until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      retries   <= '0;
      status    <= ST_OK;
      err_flags <= 4'b0000;
    end else if (in_flight && abort) begin
      status <= ST_ABORT;
    end else if (sample) begin
      if (!has_error) begin
        status <= (retries == '0) ? ST_OK : ST_CORR;
      end else begin
        err_flags <= det_error;
        if (can_retry) begin
          retries <= retries + 1'b1;
        end else begin
          status <= ST_FAIL;
        end
      end
    end
  end

  assign retry_count = retries;

`ifdef ABFT_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_events <= 16'h0000;
    end else if (sample && has_error && (err_events != 16'hFFFF)) begin
      err_events <= err_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_abft_check_ctrl.sv
// Scoreboard bench for abft_check_ctrl: random tiles checked against a per-attempt reference model.
module tb_abft_check_ctrl;

  localparam int MAXR = 2;
  localparam int RUNC = 12;
  localparam int CHKW = 2;
  localparam int DOT_OFS0 = 8;
  localparam int DOT_OFS1 = 9;
  localparam int ACC_OFS = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] det_error = 4'b0000;
  logic       start_ready, array_clr, array_en, det_clr, dot_valid, acc_valid, done, busy;
  logic [1:0] status;
  logic [3:0] err_flags;
  logic [1:0] retry_count;

  abft_check_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort      (abort),
    .array_clr  (array_clr),
    .array_en   (array_en),
    .det_clr    (det_clr),
    .dot_valid  (dot_valid),
    .acc_valid  (acc_valid),
    .det_error  (det_error),
    .done       (done),
    .status     (status),
    .err_flags  (err_flags),
    .retry_count(retry_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] status;
    int         retries;
    logic [3:0] flags;
    int         latency;
    int         en_cycles;
    int         dots;
    int         accs;
    int         preps;
    bit         check_gap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ex;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] errs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: each attempt costs PREP + run + check wait; DONE adds one more cycle.
  function automatic exp_t model(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2, input int ab);
    exp_t       x;
    logic [3:0] e[3];
    int         n;
    e[0] = e0; e[1] = e1; e[2] = e2;
    x.check_gap = 1'b0;
    if (ab >= -1) begin
      x.status    = 2'b11;
      x.retries   = 0;
      x.flags     = 4'b0000;
      x.latency   = ab + 3;
      x.en_cycles = (ab < 0) ? 0 : ((ab < RUNC) ? ab + 1 : RUNC);
      x.dots      = int'(ab >= 7) + int'(ab >= 8);
      x.accs      = int'(ab >= 11);
      x.preps     = 1;
    end else begin
      x.flags  = 4'b0000;
      x.status = 2'b10;
      n        = MAXR + 1;
      for (int a = 0; a <= MAXR; a++) begin
        if (e[a] == 4'b0000) begin
          x.status = (a == 0) ? 2'b00 : 2'b01;
          n        = a + 1;
          break;
        end
        x.flags = e[a];
      end
      x.retries   = n - 1;
      x.latency   = (1 + RUNC + CHKW) * n + 1;
      x.en_cycles = RUNC * n;
      x.dots      = 2 * n;
      x.accs      = n;
      x.preps     = n;
    end
    return x;
  endfunction

  // Monitor state, sampled on the falling edge.
  int acc_cyc = 0, last_done_cyc = -100, cur_gap = 0, tile_id = 0;
  int en_cnt, dot_cnt, acc_cnt, prep_cnt, misplaced, bad_hs, last_clr;
  bit in_tile = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_tile = 1'b0;
    end else if (start_valid && start_ready) begin
      acc_cyc  = cyc;
      cur_gap  = cyc - last_done_cyc;
      tile_id++;
      in_tile  = 1'b1;
      en_cnt = 0; dot_cnt = 0; acc_cnt = 0; prep_cnt = 0; misplaced = 0; bad_hs = 0;
      last_clr = cyc;
    end else if (in_tile) begin
      if (array_clr) begin
        prep_cnt++;
        last_clr = cyc;
      end
      if (array_en) en_cnt++;
      if (dot_valid) begin
        dot_cnt++;
        if ((cyc - last_clr != DOT_OFS0) && (cyc - last_clr != DOT_OFS1)) misplaced++;
      end
      if (acc_valid) begin
        acc_cnt++;
        if (cyc - last_clr != ACC_OFS) misplaced++;
      end
      if (start_ready || !busy) bad_hs++;
      if (done) begin
        in_tile       = 1'b0;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("done_without_expectation", exp_q.size(), 1);
        end else begin
          ex = exp_q.pop_front();
          checkOutput("status", status, ex.status);
          checkOutput("retry_count", retry_count, ex.retries);
          checkOutput("err_flags", err_flags, ex.flags);
          checkOutput("done_latency", cyc - acc_cyc, ex.latency);
          checkOutput("array_en_cycles", en_cnt, ex.en_cycles);
          checkOutput("dot_valid_cycles", dot_cnt, ex.dots);
          checkOutput("acc_valid_cycles", acc_cnt, ex.accs);
          checkOutput("prep_pulses", prep_cnt, ex.preps);
          checkOutput("strobe_position", misplaced, 0);
          checkOutput("busy_handshake", bad_hs, 0);
          if (ex.check_gap) checkOutput("back_to_back_gap", cur_gap, 1);
        end
      end
    end else if (done) begin
      checkOutput("spurious_done", done, 0);
    end
  end

  // det_error follows the attempt number, advancing on every array_clr pulse.
  int drv_tile = 0;
  int att = -1;
  always @(posedge clk) begin
    #1;
    if (tile_id != drv_tile) begin
      drv_tile = tile_id;
      att      = -1;
    end
    if (array_clr) begin
      att++;
      det_error = (att >= 0 && att < 3) ? errs[att] : 4'hF;
    end
  end

  task automatic doReset();
    start_valid = 1'b0;
    abort       = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                               input int ab, input bit hold);
    exp_t x;
    int   base, t0;
    bit   ok;
    base = exp_q.size();
    errs[0] = e0; errs[1] = e1; errs[2] = e2;
    x = model(e0, e1, e2, ab);
    exp_q.push_back(x);
    if (hold) begin
      x.check_gap = 1'b1;
      exp_q.push_back(x);
    end
    t0 = tile_id;
    start_valid = 1'b1;
    abort       = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (tile_id != t0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!hold) start_valid = 1'b0;
    if (!ok) begin
      checkOutput("accept_timeout", tile_id, t0 + 1);
      exp_q.delete();
      doReset();
      return;
    end
    if (ab >= -1) begin
      while (cyc < acc_cyc + 2 + ab) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    for (int i = 0; i < 400 && exp_q.size() > base; i++) begin
      @(posedge clk);
      #1;
      if (hold && (tile_id - t0 >= 2)) start_valid = 1'b0;
    end
    start_valid = 1'b0;
    if (exp_q.size() > base) begin
      checkOutput("done_timeout", exp_q.size(), base);
      exp_q.delete();
      doReset();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic resetMidRun();
    int t0;
    errs[0] = 4'b0000; errs[1] = 4'b0000; errs[2] = 4'b0000;
    t0 = tile_id;
    start_valid = 1'b1;
    for (int i = 0; i < 20 && tile_id == t0; i++) begin
      @(posedge clk);
      #1;
    end
    start_valid = 1'b0;
    while (cyc < acc_cyc + 2 + 3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("array_en_before_reset", array_en, 1);
    rst = 1'b1;
    #1;
    checkOutput("det_clr_during_rst", det_clr, 1);
    @(posedge clk);
    #1;
    checkOutput("rst_start_ready", start_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_array_en", array_en, 0);
    checkOutput("rst_dot_acc", {dot_valid, acc_valid, array_clr, done}, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_err_flags", err_flags, 0);
    checkOutput("rst_retry_count", retry_count, 0);
    checkOutput("rst_det_clr", det_clr, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_start_ready", start_ready, 1);
    checkOutput("post_rst_det_clr", det_clr, 0);
  endtask

  function automatic logic [3:0] randErr();
    logic [3:0] v;
    if ($urandom_range(0, 1) == 0) return 4'b0000;
    v = 4'($urandom_range(1, 15));
    return v;
  endfunction

  initial begin
    $display("[TB] starting abft_check_ctrl bench");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_start_ready", start_ready, 1);
    checkOutput("reset_det_clr", det_clr, 1);
    checkOutput("reset_outputs", {array_en, dot_valid, acc_valid, array_clr, done, busy}, 0);
    checkOutput("reset_results", {status, err_flags, retry_count}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(4'b0000, 4'b0000, 4'b0000, -2, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, -2, 1'b0);
    applyStimulus(4'b1001, 4'b1001, 4'b1001, -2, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 5, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 13, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, -1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, -2, 1'b1);
    applyStimulus(4'b0011, 4'b0101, 4'b0000, -2, 1'b0);
    resetMidRun();

    for (int t = 0; t < 25; t++) begin
      logic [3:0] a, b, c;
      int         ab;
      a  = randErr();
      b  = randErr();
      c  = randErr();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) - 1 : -2;
      applyStimulus(a, b, c, ab, 1'b0);
    end

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/abft_check_ctrl.md
Name: abft_check_ctrl

Overview:
- Sequences one checked tile operation on the systolic array and its ABFT checksum detector.
- Accepts a tile request, clears the array and detector, and runs the array for a fixed cycle count.
- Pulses the detector's dot and accumulator strobes at the correct cycles, then samples the 4-bit error vector.
- On error, re-executes the tile up to maxRetries times before reporting failure. Sits between the tile scheduler and the array/detector pair.

Parameters:
- arraySize, 4, systolic array dimension.
- maxRetries, 2, re-executions allowed after a detected error (0 = no retry).
- runCycles, 3*arraySize, array_en cycles per attempt.
- dotCycle, 2*arraySize-1, run-cycle index of the first of two dot_valid cycles.
- accCycle, 3*arraySize-1, run-cycle index of the single acc_valid cycle.
- checkWait, 2, cycles from the acc_valid cycle to detector error sampling.
- cntWidth, $clog2(3*arraySize+1), run counter width.
- retryWidth, $clog2(maxRetries+1), retry counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start_valid, input, 1, tile request.
- start_ready, output, 1, request accepted when start_valid && start_ready.
- abort, input, 1, synchronous abort of the in-flight tile.
- array_clr, output, 1, one-cycle clear to the array accumulators.
- array_en, output, 1, array compute enable.
- det_clr, output, 1, detector reset (drives detector rst).
- dot_valid, output, 1, detector valid_dot.
- acc_valid, output, 1, detector valid_acc.
- det_error, input, 4, detector error {w,x,y,z}.
- done, output, 1, one-cycle completion pulse.
- status, output, 2, 00 ok, 01 corrected-by-retry, 10 fail, 11 aborted.
- err_flags, output, 4, det_error captured from the last failing attempt.
- retry_count, output, retryWidth, retries used by the last tile.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Interface: one clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state IDLE, start_ready=1, done=0, status=00, err_flags=0, retry_count=0, array_en=0, dot_valid=0, acc_valid=0, array_clr=0, busy=0.
- det_clr=1 while rst is high. Reset mid-operation abandons the tile with no done pulse.
- States: IDLE, PREP, RUN, CHECK, DONE.
- IDLE: start_ready=1. An accepted start clears the retry counter and moves to PREP.
- PREP (1 cycle): array_clr=1, det_clr=1. Next state is RUN with run counter=0.
- RUN: array_en=1. dot_valid=1 when counter is dotCycle or dotCycle+1. acc_valid=1 when counter is accCycle. The counter increments every cycle; leave to CHECK after counter reaches runCycles-1.
- CHECK: wait counter runs 0..checkWait-1. det_error is sampled in the final CHECK cycle (the cycle accCycle+checkWait relative to run start).
  - Error =0: go to DONE. status=00 if retries=0, else 01.
  - Error ≠0 and retries<maxRetries: latch err_flags, increment retries, go to PREP.
  - Error ≠0 and retries=maxRetries: latch err_flags, status=10, go to DONE.
- DONE (1 cycle): done=1, start_ready=0. Next state is IDLE.
- status, err_flags and retry_count hold their values until the next accepted start. err_flags clears on accept.
- abort in PREP/RUN/CHECK: next state is DONE with status=11. array_en, dot_valid and acc_valid drop the following cycle. abort takes priority over a CHECK result in the same cycle. abort in IDLE/DONE is ignored.
- start_valid in any non-IDLE state is ignored. No queuing.
- Retry counter never exceeds maxRetries. With maxRetries=0, the first error means fail.

Optional Feature:
- ABFT_ERR_CNT_EN defined: adds output err_events[15:0]. It increments by 1 on each CHECK sample with det_error≠0, saturates at 16'hFFFF, and clears only on rst.
- Not defined: the port is absent and no counter logic is generated.

Decomposition:
- Package abft_ctrl_pkg:
  - state enum ctrlState_t {IDLE, PREP, RUN, CHECK, DONE}.
  - status encodings ST_OK, ST_CORR, ST_FAIL, ST_ABORT.
  - function computing default dotCycle/accCycle from arraySize.
- One sub-module, run_timer: loadable up-counter with clear and terminal-compare output, reused for the RUN and CHECK counters.

Test Plan (arraySize=4, runCycles=12, dot at run cycles 7–8, acc at 11, sample at 13):
- Clean tile: start, det_error=0 → array_en high exactly 12 cycles, dot_valid at 7 and 8, acc_valid at 11, done 16 cycles after accept, status=00, retry_count=0.
- Single error: det_error=4'b0100 on attempt 1, 0 on attempt 2 → two PREP pulses, status=01, retry_count=1, err_flags=4'b0100.
- Persistent error: det_error=4'b1001 on all attempts with maxRetries=2 → three attempts, status=10, retry_count=2, err_flags=4'b1001.
- Abort: assert abort at run cycle 5 → array_en low the next cycle, no acc_valid, done next cycle, status=11.
- Abort and error in the same cycle: abort in the sampling CHECK cycle with det_error=4'b0001 → status=11, no retry.
- Reset mid-RUN plus back-to-back: rst at run cycle 3 → all outputs at reset values, det_clr=1 during rst, start_ready=1 after. start_valid held high through DONE → second tile accepted only in IDLE. With ABFT_ERR_CNT_EN, err_events counts 3 after the persistent-error case.
